routine_scheduler: RTL and testbench

Sequences the four display routines that feed the routine decoder. Picks the next routine from the random bus and drives the decoder's 2-bit select. Pulses a routine-reset strobe, then waits for the selected routine's completion bit (bit 46 of its bus) or a timeout. After an inter-routine gap, it picks again.

---
 rtl/routine_scheduler_if.sv | 13 +
 rtl/routine_scheduler.sv | 83 ++++++++
 tb/tb_routine_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/routine_scheduler_if.sv
// routine_scheduler_if: handshake bundle between the routine scheduler and its environment.
interface routine_scheduler_if;
   logic        Enable;
   logic [15:0] Random;
   logic [3:0]  RoutineDone;
   logic [1:0]  Select;
   logic        NewChoice;
   logic        Active;
   logic        TimedOut;
   logic [7:0]  RoutineCount;
   modport master (output Enable, Random, RoutineDone, input Select, NewChoice, Active, TimedOut, RoutineCount);
   modport slave  (input Enable, Random, RoutineDone, output Select, NewChoice, Active, TimedOut, RoutineCount);
endinterface

// File: rtl/routine_scheduler.sv
// routine_scheduler: picks a display routine, strobes its reset, waits for done/timeout, then idles a gap.
// Define NO_REPEAT_SELECT_EN to force consecutive picks to differ.
module routine_scheduler #(
   parameter int RESET_CYCLES = 2,
   parameter int TIMEOUT      = 50000000,
   parameter int GAP_CYCLES   = 25000000,
   parameter int CNT_W        = 32
) (
   input  logic Clock,
   input  logic ResetN,
   routine_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PICK, PULSE, RUN, GAP} state_t;
   state_t state, next;
   logic [CNT_W-1:0] count, count_next;
   logic [1:0] sel, pick;
   logic [7:0] done_cnt;
   logic nc, act, to, done, timeout;
   logic unused_random;
   assign unused_random = ^{bus.Random[15:8], bus.Random[5:0]};
   assign done = bus.RoutineDone[sel];
   assign timeout = count == CNT_W'(TIMEOUT - 1);
`ifdef NO_REPEAT_SELECT_EN
   assign pick = (bus.Random[7:6] == sel) ? bus.Random[7:6] + 2'd1 : bus.Random[7:6];
`else
   assign pick = bus.Random[7:6];
`endif
   always_comb begin
      next = state;
      count_next = count + 1'b1;
      case (state)
         IDLE: begin
            next = bus.Enable ? PICK : IDLE;
            count_next = count;
         end
         PICK: begin
            next = PULSE;
            count_next = '0;
         end
         PULSE: if (count == CNT_W'(RESET_CYCLES - 1)) begin
            next = RUN;
            count_next = '0;
         end
         RUN: if (done || timeout) begin
            next = GAP;
            count_next = '0;
         end
         GAP: if (count == CNT_W'(GAP_CYCLES - 1)) begin
            next = bus.Enable ? PICK : IDLE;
            count_next = '0;
         end
         default: begin
            next = IDLE;
            count_next = '0;
         end
      endcase
   end
   // Output flops are loaded from the next state so every output is a register.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
         count <= '0;
         sel <= '0;
         nc <= 1'b0;
         act <= 1'b0;
         to <= 1'b0;
         done_cnt <= '0;
      end else begin
         state <= next;
         count <= count_next;
         sel <= (state == PICK) ? pick : sel;
         nc <= next == PULSE;
         act <= (next == PULSE) || (next == RUN);
         to <= (state == RUN) && timeout && !done;
         done_cnt <= done_cnt + 8'((state == RUN) && (next == GAP));
      end
   end
   assign bus.Select = sel;
   assign bus.NewChoice = nc;
   assign bus.Active = act;
   assign bus.TimedOut = to;
   assign bus.RoutineCount = done_cnt;
endmodule

// File: tb/tb_routine_scheduler.sv
// tb_routine_scheduler: directed checks of the routine scheduler with RESET_CYCLES=2, TIMEOUT=16, GAP_CYCLES=3.
module tb_routine_scheduler;
   logic Clock, ResetN;
   int total = 0, bad = 0;
   routine_scheduler_if bus();
   routine_scheduler #(.RESET_CYCLES(2), .TIMEOUT(16), .GAP_CYCLES(3), .CNT_W(32)) dut (.Clock(Clock), .ResetN(ResetN), .bus(bus));
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic cyc;
      @(posedge Clock);
      #1;
   endtask
   task automatic apply_reset;
      bus.Enable = 1'b0;
      bus.Random = '0;
      bus.RoutineDone = '0;
      ResetN = 1'b0;
      cyc();
      ResetN = 1'b1;
      cyc();
   endtask
   // From IDLE: PICK, two PULSE cycles, then sitting in RUN cycle 1.
   task automatic start(input logic [15:0] r);
      bus.Enable = 1'b1;
      bus.Random = r;
      repeat (4) cyc();
   endtask
   task automatic test_reset;
      ResetN = 1'b1;
      bus.Enable = 1'b0;
      bus.Random = '0;
      bus.RoutineDone = '0;
      #2 ResetN = 1'b0;
      repeat (2) cyc();
      total++; if (bus.NewChoice !== 1'b0) begin bad++; $display("FAIL rst_nc got=%b exp=0", bus.NewChoice); end
      total++; if (bus.Active !== 1'b0) begin bad++; $display("FAIL rst_act got=%b exp=0", bus.Active); end
      total++; if (bus.TimedOut !== 1'b0) begin bad++; $display("FAIL rst_to got=%b exp=0", bus.TimedOut); end
      total++; if (bus.Select !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", bus.Select); end
      total++; if (bus.RoutineCount !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.RoutineCount); end
      ResetN = 1'b1;
      repeat (3) cyc();
      total++; if (bus.Active !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b exp=0", bus.Active); end
   endtask
   task automatic test_basic;
      apply_reset();
      bus.Enable = 1'b1;
      bus.Random = 16'h00C0;
      cyc();
      total++; if ({bus.NewChoice, bus.Active} !== 2'b00) begin bad++; $display("FAIL basic_pick got=%b exp=00", {bus.NewChoice, bus.Active}); end
      cyc();
      total++; if ({bus.NewChoice, bus.Active} !== 2'b11) begin bad++; $display("FAIL basic_pulse1 got=%b exp=11", {bus.NewChoice, bus.Active}); end
      total++; if (bus.Select !== 2'd3) begin bad++; $display("FAIL basic_sel got=%0d exp=3", bus.Select); end
      cyc();
      total++; if (bus.NewChoice !== 1'b1) begin bad++; $display("FAIL basic_pulse2 got=%b exp=1", bus.NewChoice); end
      cyc();
      total++; if ({bus.NewChoice, bus.Active} !== 2'b01) begin bad++; $display("FAIL basic_run1 got=%b exp=01", {bus.NewChoice, bus.Active}); end
      repeat (4) cyc();
      total++; if (bus.RoutineCount !== 8'd0) begin bad++; $display("FAIL basic_cnt0 got=%0d exp=0", bus.RoutineCount); end
      bus.RoutineDone = 4'b1000;
      cyc();
      bus.RoutineDone = 4'b0000;
      total++; if (bus.Active !== 1'b0) begin bad++; $display("FAIL basic_gap got=%b exp=0", bus.Active); end
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=1", bus.RoutineCount); end
      total++; if (bus.TimedOut !== 1'b0) begin bad++; $display("FAIL basic_to got=%b exp=0", bus.TimedOut); end
      repeat (3) begin
         cyc();
         total++; if ({bus.NewChoice, bus.Active} !== 2'b00) begin bad++; $display("FAIL basic_gap_pick got=%b exp=00", {bus.NewChoice, bus.Active}); end
      end
      cyc();
      total++; if (bus.NewChoice !== 1'b1) begin bad++; $display("FAIL basic_repick got=%b exp=1", bus.NewChoice); end
   endtask
   task automatic test_timeout;
      apply_reset();
      start(16'h0040);
      bus.Enable = 1'b0;
      total++; if (bus.Select !== 2'd1) begin bad++; $display("FAIL to_sel got=%0d exp=1", bus.Select); end
      for (int i = 1; i < 16; i++) begin
         cyc();
         total++; if ({bus.Active, bus.TimedOut} !== 2'b10) begin bad++; $display("FAIL to_run%0d got=%b exp=10", i + 1, {bus.Active, bus.TimedOut}); end
      end
      cyc();
      total++; if ({bus.Active, bus.TimedOut} !== 2'b01) begin bad++; $display("FAIL to_pulse got=%b exp=01", {bus.Active, bus.TimedOut}); end
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL to_cnt got=%0d exp=1", bus.RoutineCount); end
      cyc();
      total++; if (bus.TimedOut !== 1'b0) begin bad++; $display("FAIL to_once got=%b exp=0", bus.TimedOut); end
      repeat (6) cyc();
      total++; if ({bus.NewChoice, bus.Active} !== 2'b00) begin bad++; $display("FAIL to_idle got=%b exp=00", {bus.NewChoice, bus.Active}); end
   endtask
   task automatic test_collide;
      apply_reset();
      start(16'h0040);
      bus.Enable = 1'b0;
      repeat (15) cyc();
      bus.RoutineDone = 4'b0010;
      cyc();
      bus.RoutineDone = 4'b0000;
      total++; if ({bus.Active, bus.TimedOut} !== 2'b00) begin bad++; $display("FAIL col_to got=%b exp=00", {bus.Active, bus.TimedOut}); end
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL col_cnt got=%0d exp=1", bus.RoutineCount); end
      repeat (4) cyc();
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL col_cnt_hold got=%0d exp=1", bus.RoutineCount); end
   endtask
   task automatic test_wrong_done;
      apply_reset();
      bus.RoutineDone = 4'b1011;
      start(16'h0080);
      bus.Enable = 1'b0;
      total++; if (bus.Select !== 2'd2) begin bad++; $display("FAIL wd_sel got=%0d exp=2", bus.Select); end
      repeat (15) cyc();
      total++; if (bus.Active !== 1'b1) begin bad++; $display("FAIL wd_run16 got=%b exp=1", bus.Active); end
      cyc();
      total++; if ({bus.Active, bus.TimedOut} !== 2'b01) begin bad++; $display("FAIL wd_to got=%b exp=01", {bus.Active, bus.TimedOut}); end
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL wd_cnt got=%0d exp=1", bus.RoutineCount); end
      bus.RoutineDone = 4'b0000;
   endtask
   task automatic test_mid_reset;
      logic [1:0] exp_sel;
`ifdef NO_REPEAT_SELECT_EN
      exp_sel = 2'd0;
`else
      exp_sel = 2'd3;
`endif
      apply_reset();
      bus.RoutineDone = 4'b1000;
      start(16'h00C0);
      cyc();
      bus.RoutineDone = 4'b0000;
      total++; if ({bus.Active, bus.RoutineCount} !== {1'b0, 8'd1}) begin bad++; $display("FAIL mr_min_run got=%b/%0d exp=0/1", bus.Active, bus.RoutineCount); end
      repeat (6) cyc();
      total++; if ({bus.NewChoice, bus.Active} !== 2'b01) begin bad++; $display("FAIL mr_run got=%b exp=01", {bus.NewChoice, bus.Active}); end
      total++; if (bus.Select !== exp_sel) begin bad++; $display("FAIL mr_sel2 got=%0d exp=%0d", bus.Select, exp_sel); end
      #2 ResetN = 1'b0;
      #1;
      total++; if ({bus.NewChoice, bus.Active, bus.TimedOut} !== 3'b000) begin bad++; $display("FAIL mr_async got=%b exp=000", {bus.NewChoice, bus.Active, bus.TimedOut}); end
      total++; if ({bus.Select, bus.RoutineCount} !== 10'd0) begin bad++; $display("FAIL mr_regs got=%0d/%0d exp=0/0", bus.Select, bus.RoutineCount); end
      bus.Enable = 1'b0;
      cyc();
      ResetN = 1'b1;
      repeat (3) cyc();
      total++; if (bus.Active !== 1'b0) begin bad++; $display("FAIL mr_idle got=%b exp=0", bus.Active); end
   endtask
   task automatic test_wrap;
      apply_reset();
      bus.RoutineDone = 4'b1111;
      bus.Enable = 1'b1;
      repeat (5) cyc();
      total++; if (bus.RoutineCount !== 8'd1) begin bad++; $display("FAIL wrap_first got=%0d exp=1", bus.RoutineCount); end
      repeat (7 * 254) cyc();
      total++; if (bus.RoutineCount !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", bus.RoutineCount); end
      repeat (7) cyc();
      total++; if (bus.RoutineCount !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", bus.RoutineCount); end
   endtask
   task automatic test_select;
      logic [1:0] exp_sel;
`ifdef NO_REPEAT_SELECT_EN
      exp_sel = 2'd3;
`else
      exp_sel = 2'd2;
`endif
      apply_reset();
      bus.RoutineDone = 4'b1111;
      bus.Enable = 1'b1;
      bus.Random = 16'h0080;
      repeat (2) cyc();
      total++; if (bus.Select !== 2'd2) begin bad++; $display("FAIL sel_first got=%0d exp=2", bus.Select); end
      repeat (7) cyc();
      total++; if ({bus.NewChoice, bus.Select} !== {1'b1, exp_sel}) begin bad++; $display("FAIL sel_second got=%0d exp=%0d", bus.Select, exp_sel); end
      bus.Enable = 1'b0;
   endtask
   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_collide();
      test_wrong_done();
      test_mid_reset();
      test_wrap();
      test_select();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
